// File: rtl/headgen_pkg.sv
// Shared types and constants for the header stripper: FSM states, status codes,
// template geometry and a saturating counter helper.
package headgen_pkg;

  localparam int TMPL_DEPTH = 64;
  localparam int TMPL_AW    = 6;
  localparam int TMPL_W     = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_BODY    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_HDR  = 2'b01,
    ST_LEN  = 2'b10,
    ST_RUNT = 2'b11
  } status_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/headstrip_template_ram.sv
// 64x9 header template: bit8 enables the compare, bits7:0 hold the expected byte.
// Synchronous write, asynchronous read.
module headstrip_template_ram
  import headgen_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic [TMPL_AW-1:0] waddr_i,
  input  logic [TMPL_W-1:0]  wdata_i,
  input  logic [TMPL_AW-1:0] raddr_i,
  output logic [TMPL_W-1:0]  rdata_o
);

  logic [TMPL_W-1:0] mem [TMPL_DEPTH];

  // NOTE: the template has no reset; management software loads it after power-up.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/header_stripper.sv
// Strips a fixed-length encapsulation header, validates it against a template and
// forwards the body. Optional length check compiled in with HEADER_STRIPPER_LENCHK_EN.
module header_stripper
  import headgen_pkg::*;
#(
  parameter int HDR_LEN = 42,
  parameter int LEN_OFS = 38,
  parameter int LEN_ADJ = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic [1:0]  out_status,
  output logic        out_status_valid,
  input  logic [8:0]  writedata_mgmt_0,
  input  logic [5:0]  writeaddr_mgmt_0,
  input  logic        we_mgmt_0,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_drop
);

  if (HDR_LEN < 4 || HDR_LEN > TMPL_DEPTH || LEN_OFS < 0 || LEN_OFS + 1 >= HDR_LEN || LEN_ADJ < 0)
  begin : g_param_check
    $error("header_stripper: illegal HDR_LEN/LEN_OFS/LEN_ADJ");
  end

  localparam logic [TMPL_AW-1:0] LAST_HDR = TMPL_AW'(HDR_LEN - 1);

  state_e            state_q;
  logic [TMPL_AW-1:0] idx_q;
  logic              hdr_err_q;
  logic              first_q;
  logic [15:0]       body_cnt_q;
  logic [7:0]        out_data_q;
  logic              out_valid_q, out_sof_q, out_eof_q, out_status_valid_q;
  status_e           out_status_q;
  logic [15:0]       cnt_ok_q, cnt_drop_q;

  logic [TMPL_AW-1:0] cur_idx;
  logic [TMPL_W-1:0]  tmpl_rdata;
  logic               hdr_mismatch;
  logic [15:0]        body_cnt_inc;
  logic               len_err;
  logic               st_fire;
  status_e            st_code;

  // A start-of-frame byte is always header byte 0, whatever the counter holds.
  assign cur_idx      = in_sof ? '0 : idx_q;
  assign hdr_mismatch = tmpl_rdata[8] && (tmpl_rdata[7:0] != in_data);
  assign body_cnt_inc = sat_inc(body_cnt_q);

  headstrip_template_ram u_tmpl (
    .clk     (clk),
    .we_i    (we_mgmt_0),
    .waddr_i (writeaddr_mgmt_0),
    .wdata_i (writedata_mgmt_0),
    .raddr_i (cur_idx),
    .rdata_o (tmpl_rdata)
  );

`ifdef HEADER_STRIPPER_LENCHK_EN
  logic [15:0] len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
    end else if (in_valid && (in_sof || state_q == S_HEADER)) begin
      if (cur_idx == TMPL_AW'(LEN_OFS))     len_q[15:8] <= in_data;
      if (cur_idx == TMPL_AW'(LEN_OFS + 1)) len_q[7:0]  <= in_data;
    end
  end

  assign len_err = {1'b0, len_q} != (17'(body_cnt_inc) + 17'(LEN_ADJ));
`else
  assign len_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    st_fire = 1'b0;
    st_code = ST_OK;
    if (in_valid) begin
      if (in_sof) begin
        st_fire = (state_q != S_IDLE) || in_eof;
        st_code = ST_RUNT;
      end else if (in_eof) begin
        case (state_q)
          S_HEADER:  begin st_fire = 1'b1; st_code = ST_RUNT; end
          S_BODY:    begin st_fire = 1'b1; st_code = len_err ? ST_LEN : ST_OK; end
          S_DISCARD: begin st_fire = 1'b1; st_code = ST_HDR; end
          default:   ;
        endcase
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= S_IDLE;
      idx_q              <= '0;
      hdr_err_q          <= 1'b0;
      first_q            <= 1'b0;
      body_cnt_q         <= '0;
      out_data_q         <= '0;
      out_valid_q        <= 1'b0;
      out_sof_q          <= 1'b0;
      out_eof_q          <= 1'b0;
      out_status_q       <= ST_OK;
      out_status_valid_q <= 1'b0;
      cnt_ok_q           <= '0;
      cnt_drop_q         <= '0;
    end else begin
      out_valid_q        <= 1'b0;
      out_sof_q          <= 1'b0;
      out_eof_q          <= 1'b0;
      out_status_valid_q <= 1'b0;

      if (st_fire) begin
        out_status_valid_q <= 1'b1;
        out_status_q       <= st_code;
        if (st_code == ST_OK) cnt_ok_q   <= sat_inc(cnt_ok_q);
        else                  cnt_drop_q <= sat_inc(cnt_drop_q);
      end

      if (in_valid) begin
        if (in_sof) begin
          state_q    <= in_eof ? S_IDLE : S_HEADER;
          idx_q      <= TMPL_AW'(1);
          hdr_err_q  <= hdr_mismatch;
          body_cnt_q <= '0;
        end else begin
          case (state_q)
            S_HEADER: begin
              idx_q     <= idx_q + TMPL_AW'(1);
              hdr_err_q <= hdr_err_q | hdr_mismatch;
              if (in_eof) begin
                state_q <= S_IDLE;
              end else if (idx_q == LAST_HDR) begin
                state_q    <= (hdr_err_q | hdr_mismatch) ? S_DISCARD : S_BODY;
                first_q    <= 1'b1;
                body_cnt_q <= '0;
              end
            end
            S_BODY: begin
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
              out_sof_q   <= first_q;
              out_eof_q   <= in_eof;
              first_q     <= 1'b0;
              body_cnt_q  <= body_cnt_inc;
              if (in_eof) state_q <= S_IDLE;
            end
            S_DISCARD: if (in_eof) state_q <= S_IDLE;
            default:   ;
          endcase
        end
      end
    end
  end

  assign out_data         = out_data_q;
  assign out_valid        = out_valid_q;
  assign out_sof          = out_sof_q;
  assign out_eof          = out_eof_q;
  assign out_status       = out_status_q;
  assign out_status_valid = out_status_valid_q;
  assign cnt_ok           = cnt_ok_q;
  assign cnt_drop         = cnt_drop_q;

endmodule
